// File: rtl/mem_copy_dma_pkg.sv
// Shared definitions for the memory-to-memory copy engine.
// The state encoding and default widths are reused by the bench.
package mem_copy_dma_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mem_copy_dma.sv
// Byte-wise memory copy engine that borrows the processor's single data-memory port.
// Each byte takes one read cycle and one write cycle; the processor stalls while busy.
module mem_copy_dma
  import mem_copy_dma_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] len,
  input  logic          cpu_wr_en,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_dat_in,
  input  logic [DW-1:0] mem_dat_out,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_dat_in,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] count_q, count_d;
  logic [DW-1:0] buf_q, buf_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    count_d = count_q;
    buf_d   = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = ST_DONE;
          end else begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            count_d = len;
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        buf_d   = mem_dat_out;
        state_d = ST_WR;
      end
      ST_WR: begin
        // Pointers wrap naturally at the top of the address space.
        src_d   = src_q + AW'(1);
        dst_d   = dst_q + AW'(1);
        count_d = count_q - AW'(1);
        state_d = (count_q == AW'(1)) ? ST_DONE : ST_RD;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      buf_q   <= buf_d;
    end
  end

  // Port mux: the engine owns the memory in RD/WR, the processor otherwise.
  always_comb begin
    mem_addr   = cpu_addr;
    mem_wr_en  = cpu_wr_en;
    mem_dat_in = cpu_dat_in;
    case (state_q)
      ST_RD: begin
        mem_addr   = src_q;
        mem_wr_en  = 1'b0;
        mem_dat_in = buf_q;
      end
      ST_WR: begin
        mem_addr   = dst_q;
        mem_wr_en  = 1'b1;
        mem_dat_in = buf_q;
      end
      default: ;
    endcase
    // A reset landing mid-write must not let that byte through.
    if (reset) mem_wr_en = 1'b0;
  end

  assign busy = (state_q == ST_RD) || (state_q == ST_WR);
  assign done = (state_q == ST_DONE);

endmodule
